// File: rtl/sym_counter_pkg.sv
// Shared types and widths for the game-period sequencer and its symbol-tick divider.
package sym_counter_pkg;

    localparam int unsigned LEVEL_W      = 4;
    localparam int unsigned SEC_W        = 8;
    localparam int unsigned SYMGEN_CNT_W = 27;

    typedef enum logic [2:0] {
        IDLE,
        PRELIM,
        GAME,
        ANSWER,
        POST,
        DONE
    } period_state_t;

    typedef struct packed {
        logic prelim;
        logic game;
        logic answer;
        logic post;
        logic done;
    } period_flags_t;

    // One-hot period flags for a given state (IDLE has none).
    function automatic period_flags_t flags_for(period_state_t st);
        period_flags_t f;
        f = '0;
        case (st)
            PRELIM:  f.prelim = 1'b1;
            GAME:    f.game   = 1'b1;
            ANSWER:  f.answer = 1'b1;
            POST:    f.post   = 1'b1;
            DONE:    f.done   = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    // Signed arithmetic so a large level clamps to the floor instead of wrapping.
    function automatic logic [SYMGEN_CNT_W-1:0] symgen_period(int base, int step, int floor_p, int level);
        int p;
        p = base - level * step;
        if (p < floor_p) begin
            p = floor_p;
        end
        return SYMGEN_CNT_W'(p);
    endfunction

endpackage

// File: rtl/symgen_divider.sv
// Programmable cycle divider producing the level-scaled symbol-generator tick.
module symgen_divider
    import sym_counter_pkg::*;
(
    input  logic                    Clk100M,
    input  logic                    ResetN,
    input  logic                    Enable,
    input  logic                    Clear,
    input  logic [SYMGEN_CNT_W-1:0] Period,
    output logic                    Tick
);

    logic [SYMGEN_CNT_W-1:0] count;

    // Clear wins over Enable; a disabled cycle holds the count without ticking.
    always_ff @(posedge Clk100M) begin
        if (!ResetN) begin
            count <= '0;
            Tick  <= 1'b0;
        end else if (Clear) begin
            count <= '0;
            Tick  <= 1'b0;
        end else if (Enable) begin
            if (count == Period - SYMGEN_CNT_W'(1)) begin
                count <= '0;
                Tick  <= 1'b1;
            end else begin
                count <= count + SYMGEN_CNT_W'(1);
                Tick  <= 1'b0;
            end
        end else begin
            Tick <= 1'b0;
        end
    end

endmodule

// File: rtl/period_sequencer.sv
// Game-period controller: PRELIM -> GAME -> ANSWER -> POST per level, level advance, symbol tick.
// Optional freeze on Pause is built only when SEQ_PAUSE_EN is defined.
module period_sequencer
    import sym_counter_pkg::*;
#(
    parameter int unsigned PRELIM_SEC  = 3,
    parameter int unsigned GAME_SEC    = 20,
    parameter int unsigned ANSWER_SEC  = 10,
    parameter int unsigned POST_SEC    = 2,
    parameter int unsigned MAX_LEVEL   = 9,
    parameter int unsigned SYMGEN_BASE = 100000000,
    parameter int unsigned SYMGEN_STEP = 5000000,
    parameter int unsigned SYMGEN_MIN  = 10000000
) (
    input  logic               Clk100M,
    input  logic               ResetN,
    input  logic               Tick1Hz,
    input  logic               Start,
    input  logic               AnswerCorrect,
    input  logic               AnswerWrong,
    input  logic               Pause,
    output logic               PrelimPeriod,
    output logic               GamePeriod,
    output logic               AnswerPeriod,
    output logic               PostPeriod,
    output logic               GameOver,
    output logic [LEVEL_W-1:0] Level,
    output logic               LevelChng,
    output logic [SEC_W-1:0]   SecLeft,
    output logic               SymGenTick
);

    if (PRELIM_SEC == 0 || GAME_SEC == 0 || ANSWER_SEC == 0 || POST_SEC == 0) begin : g_bad_sec
        $error("period_sequencer: every *_SEC parameter must be non-zero");
    end

    period_state_t           state;
    period_flags_t           flags;
    logic                    correct;
    logic                    frozen;
    logic                    tick_ok;
    logic                    expire;
    logic                    answered;
    logic                    div_enable;
    logic                    div_clear;
    logic [SYMGEN_CNT_W-1:0] sym_period;

`ifdef SEQ_PAUSE_EN
    assign frozen = Pause && (state inside {PRELIM, GAME, ANSWER, POST});
`else
    logic pause_unused;
    assign pause_unused = Pause;
    assign frozen       = 1'b0;
`endif

    assign tick_ok  = Tick1Hz && !frozen;
    assign expire   = tick_ok && (SecLeft == SEC_W'(1));
    assign answered = (AnswerCorrect || AnswerWrong) && !frozen;

    // The divider is stopped on the expiring edge so no tick leaks into ANSWER.
    assign div_clear  = (state != GAME);
    assign div_enable = (state == GAME) && !frozen && !expire;
    assign sym_period = symgen_period(int'(SYMGEN_BASE), int'(SYMGEN_STEP), int'(SYMGEN_MIN), int'(Level));

    always_ff @(posedge Clk100M) begin
        if (!ResetN) begin
            state     <= IDLE;
            flags     <= '0;
            Level     <= '0;
            LevelChng <= 1'b0;
            SecLeft   <= '0;
            correct   <= 1'b0;
        end else begin
            LevelChng <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state   <= PRELIM;
                        flags   <= flags_for(PRELIM);
                        SecLeft <= SEC_W'(PRELIM_SEC);
                        Level   <= '0;
                    end
                end
                PRELIM: begin
                    if (expire) begin
                        state   <= GAME;
                        flags   <= flags_for(GAME);
                        SecLeft <= SEC_W'(GAME_SEC);
                    end else if (tick_ok) begin
                        SecLeft <= SecLeft - SEC_W'(1);
                    end
                end
                GAME: begin
                    if (expire) begin
                        state   <= ANSWER;
                        flags   <= flags_for(ANSWER);
                        SecLeft <= SEC_W'(ANSWER_SEC);
                    end else if (tick_ok) begin
                        SecLeft <= SecLeft - SEC_W'(1);
                    end
                end
                ANSWER: begin
                    // An answer beats a same-cycle tick; both answers together count as wrong.
                    if (answered || expire) begin
                        state   <= POST;
                        flags   <= flags_for(POST);
                        SecLeft <= SEC_W'(POST_SEC);
                        correct <= answered && AnswerCorrect && !AnswerWrong;
                    end else if (tick_ok) begin
                        SecLeft <= SecLeft - SEC_W'(1);
                    end
                end
                POST: begin
                    if (expire) begin
                        if (correct && (Level < LEVEL_W'(MAX_LEVEL))) begin
                            state     <= PRELIM;
                            flags     <= flags_for(PRELIM);
                            SecLeft   <= SEC_W'(PRELIM_SEC);
                            Level     <= Level + LEVEL_W'(1);
                            LevelChng <= 1'b1;
                        end else begin
                            state   <= DONE;
                            flags   <= flags_for(DONE);
                            SecLeft <= '0;
                        end
                    end else if (tick_ok) begin
                        SecLeft <= SecLeft - SEC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    flags <= '0;
                end
            endcase
        end
    end

    assign PrelimPeriod = flags.prelim;
    assign GamePeriod   = flags.game;
    assign AnswerPeriod = flags.answer;
    assign PostPeriod   = flags.post;
    assign GameOver     = flags.done;

    symgen_divider u_symgen_divider (
        .Clk100M (Clk100M),
        .ResetN  (ResetN),
        .Enable  (div_enable),
        .Clear   (div_clear),
        .Period  (sym_period),
        .Tick    (SymGenTick)
    );

endmodule

// File: tb/tb_period_sequencer.sv
// Scoreboard bench for period_sequencer: randomized games checked against a phase-level model.
module tb_period_sequencer;

    localparam int PRE   = 2;
    localparam int GAM   = 3;
    localparam int ANS   = 2;
    localparam int PST   = 1;
    localparam int MAXL  = 2;
    localparam int BASE  = 20;
    localparam int STEP  = 4;
    localparam int MINP  = 8;
    localparam int TPER  = 50;
    localparam int PLO   = 25;
    localparam int PHI   = 175;
    localparam int NLEV  = 30;

    typedef struct packed {
        logic [4:0] flags;
        logic [7:0] sec;
        logic [3:0] level;
        logic       lchg;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       Tick1Hz, Start, AnswerCorrect, AnswerWrong, Pause;
    logic       PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, GameOver;
    logic [3:0] Level;
    logic       LevelChng;
    logic [7:0] SecLeft;
    logic       SymGenTick;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   mlevel = 0;
    bit   mon_en = 0;
    obs_t exp_q[$];
    int   sym_q[$];
    int   dir[10] = '{0, 0, 4, 3, 0, 2, 5, 0, 0, 0};

    period_sequencer #(
        .PRELIM_SEC  (PRE),
        .GAME_SEC    (GAM),
        .ANSWER_SEC  (ANS),
        .POST_SEC    (PST),
        .MAX_LEVEL   (MAXL),
        .SYMGEN_BASE (BASE),
        .SYMGEN_STEP (STEP),
        .SYMGEN_MIN  (MINP)
    ) dut (
        .Clk100M       (clk),
        .ResetN        (rst_n),
        .Tick1Hz       (Tick1Hz),
        .Start         (Start),
        .AnswerCorrect (AnswerCorrect),
        .AnswerWrong   (AnswerWrong),
        .Pause         (Pause),
        .PrelimPeriod  (PrelimPeriod),
        .GamePeriod    (GamePeriod),
        .AnswerPeriod  (AnswerPeriod),
        .PostPeriod    (PostPeriod),
        .GameOver      (GameOver),
        .Level         (Level),
        .LevelChng     (LevelChng),
        .SecLeft       (SecLeft),
        .SymGenTick    (SymGenTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ph: 0 idle, 1 prelim, 2 game, 3 answer, 4 post, 5 done
    function automatic obs_t mk(input int ph, input int sec, input int lvl, input bit lc);
        obs_t o;
        o.flags = {ph == 1, ph == 2, ph == 3, ph == 4, ph == 5};
        o.sec   = 8'(sec);
        o.level = 4'(lvl);
        o.lchg  = lc;
        return o;
    endfunction

    function automatic int sym_p(input int lvl);
        int p;
        p = BASE - lvl * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic bit pnoise();
`ifdef SEQ_PAUSE_EN
        return 1'b0;
`else
        return ($urandom % 4) == 0;
`endif
    endfunction

    // Monitor: every change of the period/second/level view pops one expectation.
    obs_t cur, prev, ex;
    bit   have_prev = 0;
    int   et;
    always @(negedge clk) begin
        if (mon_en) begin
            cur.flags = {PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, GameOver};
            cur.sec   = SecLeft;
            cur.level = Level;
            cur.lchg  = LevelChng;
            if (have_prev && (cur.flags !== prev.flags || cur.sec !== prev.sec || cur.level !== prev.level)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL state_change edge %0d: unexpected flags=%b sec=%0d lvl=%0d", cyc, cur.flags, cur.sec, cur.level);
                end else begin
                    ex = exp_q.pop_front();
                    if (cur !== ex) begin
                        errors++;
                        $display("FAIL state_change edge %0d: got flags=%b sec=%0d lvl=%0d lchg=%b, want flags=%b sec=%0d lvl=%0d lchg=%b",
                                 cyc, cur.flags, cur.sec, cur.level, cur.lchg, ex.flags, ex.sec, ex.level, ex.lchg);
                    end
                end
            end else if (have_prev && LevelChng !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL level_chng edge %0d: got %b with no level change, want 0", cyc, LevelChng);
            end
            if (SymGenTick !== 1'b0) begin
                checks++;
                if (sym_q.size() == 0) begin
                    errors++;
                    $display("FAIL symgen_tick edge %0d: got tick, want none", cyc);
                end else begin
                    et = sym_q.pop_front();
                    if (et != cyc) begin
                        errors++;
                        $display("FAIL symgen_tick: got tick at edge %0d, want edge %0d", cyc, et);
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    task automatic drv(input bit t, input bit s, input bit c, input bit w, input bit p);
        Tick1Hz       = t;
        Start         = s;
        AnswerCorrect = c;
        AnswerWrong   = w;
        Pause         = p;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit allow_ans);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, ($urandom % 16) == 0, allow_ans && (($urandom % 16) == 0),
                allow_ans && (($urandom % 16) == 0), pnoise());
        end
    endtask

    // One second of the period, ending with the tick; returns the edge sampling that tick.
    task automatic second(input bit allow_ans, input obs_t e, output int te);
        idle(TPER - 1, allow_ans);
        exp_q.push_back(e);
        te = cyc + 1;
        drv(1'b1, ($urandom % 16) == 0, 1'b0, 1'b0, pnoise());
    endtask

    task automatic prelim_phase(output int eg);
        for (int s = PRE - 1; s >= 0; s--) begin
            second(1'b1, (s > 0) ? mk(1, s, mlevel, 1'b0) : mk(2, GAM, mlevel, 1'b0), eg);
        end
    endtask

    task automatic game_phase(input int eg, input bit do_pause, input bit do_reset, output bit aborted);
        int total, act, p, j, rk, er;
        bit pz, t;
        total = (do_pause ? GAM + 3 : GAM) * TPER;
        p     = sym_p(mlevel);
        act   = 0;
        for (int e = eg + 1; e < eg + total; e++) begin
            if (!(do_pause && (e - eg) >= PLO && (e - eg) < PHI)) begin
                act++;
                if (act % p == 0) sym_q.push_back(e);
            end
        end
        rk      = do_reset ? int'($urandom_range(1, total - 1)) : 0;
        j       = 0;
        aborted = 1'b0;
        for (int k = 1; k <= total && !aborted; k++) begin
            pz = do_pause && k >= PLO && k < PHI;
            t  = (k % TPER) == 0;
            if (k == rk) begin
                er = cyc + 1;
                while (sym_q.size() > 0 && sym_q[$] >= er) void'(sym_q.pop_back());
                exp_q.push_back(mk(0, 0, 0, 1'b0));
                rst_n = 1'b0;
                drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst_n   = 1'b1;
                mlevel  = 0;
                aborted = 1'b1;
            end else begin
                if (t && !pz) begin
                    j++;
                    exp_q.push_back((j < GAM) ? mk(2, GAM - j, mlevel, 1'b0) : mk(3, ANS, mlevel, 1'b0));
                end
                drv(t, ($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0, pz | pnoise());
            end
        end
    endtask

    // kind: 0 correct, 1 wrong, 2 both, 3 timeout, 4 correct with final tick, 5 wrong after a tick
    task automatic answer_phase(input int kind, output bit corr);
        int d, te;
        case (kind)
            0, 1, 2: begin
                d = $urandom_range(0, 45);
                idle(d, 1'b0);
                exp_q.push_back(mk(4, PST, mlevel, 1'b0));
                drv(1'b0, 1'b0, kind != 1, kind != 0, pnoise());
                corr = (kind == 0);
            end
            3: begin
                for (int s = ANS - 1; s >= 0; s--) begin
                    second(1'b0, (s > 0) ? mk(3, s, mlevel, 1'b0) : mk(4, PST, mlevel, 1'b0), te);
                end
                corr = 1'b0;
            end
            4: begin
                second(1'b0, mk(3, ANS - 1, mlevel, 1'b0), te);
                idle(TPER - 1, 1'b0);
                exp_q.push_back(mk(4, PST, mlevel, 1'b0));
                drv(1'b1, 1'b0, 1'b1, 1'b0, pnoise());
                corr = 1'b1;
            end
            default: begin
                second(1'b0, mk(3, ANS - 1, mlevel, 1'b0), te);
                d = $urandom_range(0, 40);
                idle(d, 1'b0);
                exp_q.push_back(mk(4, PST, mlevel, 1'b0));
                drv(1'b0, 1'b0, 1'b0, 1'b1, pnoise());
                corr = 1'b0;
            end
        endcase
    endtask

    task automatic post_phase(input bit corr, output bit cont);
        int te;
        for (int s = PST - 1; s > 0; s--) second(1'b1, mk(4, s, mlevel, 1'b0), te);
        if (corr && mlevel < MAXL) begin
            second(1'b1, mk(1, PRE, mlevel + 1, 1'b1), te);
            mlevel++;
            cont = 1'b1;
        end else begin
            second(1'b1, mk(5, 0, mlevel, 1'b0), te);
            cont = 1'b0;
        end
    endtask

    initial begin
        int  lvl_idx, kind, eg;
        bit  cont, corr, ab, do_pause;
        rst_n         = 1'b0;
        Tick1Hz       = 1'b0;
        Start         = 1'b0;
        AnswerCorrect = 1'b0;
        AnswerWrong   = 1'b0;
        Pause         = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, GameOver, SecLeft, Level, LevelChng} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b sec=%0d lvl=%0d lchg=%b, want all 0",
                     {PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, GameOver}, SecLeft, Level, LevelChng);
        end
        checks++;
        if (SymGenTick !== 1'b0) begin
            errors++;
            $display("FAIL reset_symgen: got %b, want 0", SymGenTick);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        lvl_idx = 0;
        while (lvl_idx < NLEV) begin
            // IDLE/DONE: answers, ticks-free noise and Pause have no effect.
            repeat ($urandom_range(0, 8)) drv(1'b0, 1'b0, ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 2) == 0);
            mlevel = 0;
            exp_q.push_back(mk(1, PRE, 0, 1'b0));
            drv(1'b0, 1'b1, 1'b0, 1'b0, ($urandom % 2) == 0);
            cont = 1'b1;
            while (cont) begin
                kind = (lvl_idx < 10) ? dir[lvl_idx] : int'($urandom_range(0, 5));
`ifdef SEQ_PAUSE_EN
                do_pause = (lvl_idx == 4) || (lvl_idx == 15);
`else
                do_pause = 1'b0;
`endif
                prelim_phase(eg);
                game_phase(eg, do_pause, (lvl_idx == 7) || (lvl_idx == 23), ab);
                if (ab) begin
                    cont = 1'b0;
                end else begin
                    answer_phase(kind, corr);
                    post_phase(corr, cont);
                end
                lvl_idx++;
            end
        end
        repeat (4) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_states: got %0d unobserved changes, want 0", exp_q.size());
        end
        checks++;
        if (sym_q.size() != 0) begin
            errors++;
            $display("FAIL pending_symgen: got %0d missing ticks, want 0", sym_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
